// File: rtl/game_sequencer.sv
// game_sequencer: snake game state machine, frame-to-step pacing and 2-entry direction queue
// Ports: clk, reset (async active-low), frame_end, dir_btn[3:0] one-hot presses,
//        start_btn, game_over, game_won -> step pulse, direction[1:0], logic_clear pulse, state[2:0]
module game_sequencer #(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic [3:0] dir_btn,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic       game_won,
    output logic       step,
    output logic [1:0] direction,
    output logic       logic_clear,
    output logic [2:0] state
);
    typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, PAUSE = 3'd2, OVER = 3'd3, WON = 3'd4} state_t;
    localparam logic [3:0] LAST = 4'(FRAMES_PER_STEP - 1);
    state_t cur, nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] q0, q1, q0_nxt, q1_nxt, qn, qn_nxt, qn_pop, dir_nxt, press, ref_dir;
    logic       rdy, start, play, onehot, accept, fire, pop, clear_nxt;
    assign state = cur;
    always_comb begin
        // rdy masks start_btn on the first edge after reset release
        start     = start_btn & rdy;
        play      = cur == PLAY;
        onehot    = dir_btn != 4'd0 && (dir_btn & (dir_btn - 4'd1)) == 4'd0;
        press     = dir_btn[1] ? 2'd1 : dir_btn[2] ? 2'd2 : dir_btn[3] ? 2'd3 : 2'd0;
        ref_dir   = qn == 2'd0 ? direction : qn == 2'd1 ? q0 : q1;
        accept    = play && onehot && qn != 2'd2 && press != ref_dir && press != (ref_dir ^ 2'b10);
        fire      = play && frame_end && cnt == LAST && !game_over && !game_won && !start;
        pop       = fire && qn != 2'd0;
        qn_pop    = qn - {1'b0, pop};
        dir_nxt   = pop ? q0 : direction;
        q0_nxt    = pop ? q1 : q0;
        q1_nxt    = q1;
        if (accept) begin
            if (qn_pop == 2'd0) q0_nxt = press;
            else q1_nxt = press;
        end
        qn_nxt    = qn_pop + {1'b0, accept};
        cnt_nxt   = play && frame_end ? (cnt == LAST ? 4'd0 : cnt + 4'd1) : cnt;
        clear_nxt = 1'b0;
        nxt       = cur;
        if (play && game_won) nxt = WON;
        else if (play && game_over) nxt = OVER;
        else if (start) begin
            if (cur == IDLE) begin
                nxt       = PLAY;
                clear_nxt = 1'b1;
                cnt_nxt   = 4'd0;
                qn_nxt    = 2'd0;
                dir_nxt   = 2'd2;
            end else nxt = cur == PLAY ? PAUSE : cur == PAUSE ? PLAY : IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= IDLE;
            direction   <= 2'd2;
            step        <= 1'b0;
            logic_clear <= 1'b0;
            cnt         <= 4'd0;
            q0          <= 2'd0;
            q1          <= 2'd0;
            qn          <= 2'd0;
            rdy         <= 1'b0;
        end else begin
            cur         <= nxt;
            direction   <= dir_nxt;
            step        <= fire;
            logic_clear <= clear_nxt;
            cnt         <= cnt_nxt;
            q0          <= q0_nxt;
            q1          <= q1_nxt;
            qn          <= qn_nxt;
            rdy         <= 1'b1;
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and random checks of game_sequencer against a queue-based model
module tb_game_sequencer;
    localparam int F = 4;
    logic clk = 1'b0, reset = 1'b0, frame_end = 1'b0, start_btn = 1'b0, game_over = 1'b0, game_won = 1'b0;
    logic [3:0] dir_btn = 4'd0;
    logic step, logic_clear;
    logic [1:0] direction;
    logic [2:0] state;
    int pass_cnt = 0, total_cnt = 0, nsteps = 0, nclear = 0, s0, c0;
    int m_state = 0, m_dir = 2, m_cnt = 0;
    int mq[$];
    int exp_q[$];
    bit m_step = 0, m_lc = 0, m_rdy = 0;

    game_sequencer #(.FRAMES_PER_STEP(F)) dut (
        .clk(clk), .reset(reset), .frame_end(frame_end), .dir_btn(dir_btn),
        .start_btn(start_btn), .game_over(game_over), .game_won(game_won),
        .step(step), .direction(direction), .logic_clear(logic_clear), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // reference model: game rules applied to plain integers and a queue
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_dir = 2; m_cnt = 0; m_step = 0; m_lc = 0; m_rdy = 0;
            mq.delete();
            exp_q.delete();
        end else begin
            bit st, fire, ok;
            int d, r;
            st = start_btn && m_rdy;
            m_rdy = 1;
            fire = m_state == 1 && frame_end && m_cnt == F - 1 && !game_over && !game_won && !st;
            ok = 0;
            d = 0;
            if (m_state == 1 && $onehot(dir_btn) && mq.size() < 2) begin
                for (int i = 0; i < 4; i++) if (dir_btn[i]) d = i;
                r = mq.size() > 0 ? mq[$] : m_dir;
                ok = d != r && d != (r ^ 2);
            end
            if (fire && mq.size() > 0) m_dir = mq.pop_front();
            if (ok) mq.push_back(d);
            if (fire) exp_q.push_back(m_dir);
            if (m_state == 1 && frame_end) m_cnt = m_cnt == F - 1 ? 0 : m_cnt + 1;
            m_step = fire;
            m_lc = 0;
            if (m_state == 1 && game_won) m_state = 4;
            else if (m_state == 1 && game_over) m_state = 3;
            else if (st) begin
                if (m_state == 0) begin
                    m_state = 1; m_lc = 1; m_cnt = 0; m_dir = 2;
                    mq.delete();
                end else m_state = m_state == 1 ? 2 : m_state == 2 ? 1 : 0;
            end
        end
    end

    // monitor: each step pops the scoreboard; state and pulses compared every cycle
    always @(negedge clk) begin
        if (reset) begin
            if (step) begin
                nsteps++;
                if (exp_q.size() == 0) chk("step_unexpected", 1, 0);
                else chk("step_dir", direction, exp_q.pop_front());
            end
            if (logic_clear) nclear++;
            chk("state", state, m_state);
            chk("step", step, m_step);
            chk("logic_clear", logic_clear, m_lc);
            chk("direction", direction, m_dir);
        end
    end

    task automatic cyc(input logic fe, input logic [3:0] db, input logic sb);
        frame_end = fe; dir_btn = db; start_btn = sb;
        @(negedge clk);
        frame_end = 0; dir_btn = 0; start_btn = 0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            cyc(1, 0, 0);
            repeat (3) cyc(0, 0, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_dir", direction, 2);
        chk("rst_step", step, 0);
        chk("rst_clear", logic_clear, 0);
        reset = 1;
        cyc(0, 0, 1);
        chk("start_after_release", state, 0);
        s0 = nsteps; c0 = nclear;
        cyc(0, 0, 1);
        frames(8);
        chk("t1_steps", nsteps - s0, 2);
        chk("t1_clear", nclear - c0, 1);
        chk("t1_dir", direction, 2);
        cyc(0, 4'd1, 0); cyc(0, 4'd2, 0); cyc(0, 4'd8, 0); cyc(0, 4'd1, 0); cyc(0, 4'd4, 0);
        frames(4);
        chk("t2_dir1", direction, 1);
        frames(4);
        chk("t2_dir2", direction, 0);
        frames(3);
        s0 = nsteps;
        cyc(1, 4'd2, 0);
        repeat (3) cyc(0, 0, 0);
        chk("t3_step", nsteps - s0, 1);
        chk("t3_dir_hold", direction, 0);
        frames(4);
        chk("t3_dir_next", direction, 1);
        frames(2);
        cyc(0, 0, 1);
        chk("t4_pause", state, 2);
        s0 = nsteps;
        frames(5);
        cyc(0, 0, 1);
        chk("t4_resume", state, 1);
        frames(1);
        chk("t4_no_step", nsteps - s0, 0);
        frames(1);
        chk("t4_step", nsteps - s0, 1);
        frames(3);
        game_over = 1; game_won = 1;
        s0 = nsteps;
        cyc(1, 0, 0);
        chk("t5_won", state, 4);
        cyc(0, 0, 0);
        chk("t5_no_step", nsteps - s0, 0);
        game_over = 0; game_won = 0;
        cyc(0, 0, 1);
        chk("t5_idle", state, 0);
        cyc(0, 0, 1);
        cyc(0, 4'd2, 0);
        cyc(0, 4'd1, 0);
        #3 reset = 0;
        #1;
        chk("t6_state", state, 0);
        chk("t6_dir", direction, 2);
        chk("t6_step", step, 0);
        chk("t6_clear", logic_clear, 0);
        @(negedge clk);
        reset = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        frames(4);
        chk("t6_queue_empty", direction, 2);
        repeat (3000) begin
            int r;
            logic [3:0] db;
            r = $urandom_range(0, 7);
            db = r == 4 || r == 5 ? 4'(1 << $urandom_range(0, 3)) : r == 6 ? 4'($urandom_range(0, 15)) : 4'd0;
            game_over = $urandom_range(0, 99) == 0;
            game_won = $urandom_range(0, 149) == 0;
            cyc($urandom_range(0, 2) == 0, db, $urandom_range(0, 39) == 0);
        end
        game_over = 0; game_won = 0;
        repeat (3) cyc(0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
